// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write/read port signals plus the register
// dump stream. The master side drives requests, the slave side is the file.
interface reg_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              REGWRITE;
    logic              REGDST;
    logic [ADDR_W-1:0] RS_ADDR;
    logic [ADDR_W-1:0] RT_ADDR;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic [DATA_W-1:0] READ_DATA_ONE;
    logic [DATA_W-1:0] READ_DATA_TWO;
    logic              DUMP_START;
    logic              DUMP_READY;
    logic              DUMP_VALID;
    logic              DUMP_BUSY;
    logic [ADDR_W-1:0] DUMP_ADDR;
    logic [DATA_W-1:0] DUMP_DATA;

    modport master (
        output REGWRITE, REGDST, RS_ADDR, RT_ADDR, RD_ADDR, WR_DATA,
        output DUMP_START, DUMP_READY,
        input  READ_DATA_ONE, READ_DATA_TWO,
        input  DUMP_VALID, DUMP_BUSY, DUMP_ADDR, DUMP_DATA
    );

    modport slave (
        input  REGWRITE, REGDST, RS_ADDR, RT_ADDR, RD_ADDR, WR_DATA,
        input  DUMP_START, DUMP_READY,
        output READ_DATA_ONE, READ_DATA_TWO,
        output DUMP_VALID, DUMP_BUSY, DUMP_ADDR, DUMP_DATA
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with two registered read ports, write-through
// bypass, optional hard-wired zero register and a ready/valid dump stream
// that walks every register once per DUMP_START.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic CLK,
    input  logic RST,
    reg_file_param_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] read_one_q, read_one_d;
    logic [DATA_W-1:0] read_two_q, read_two_d;

    dump_state_t       state_q, state_d;
    logic              dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;

    // Register 0 reads as zero when the zero-register option is enabled.
    function automatic logic [DATA_W-1:0] masked(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] value
    );
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        return value;
    endfunction

    // Pick the write target and drop writes aimed at a hard-wired zero register.
    always_comb begin
        wr_addr = bus.REGDST ? bus.RD_ADDR : bus.RT_ADDR;
        wr_en   = bus.REGWRITE && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    // Post-write view of the array; every reader samples this, which gives bypass for free.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = bus.WR_DATA;
        end
    end

    // Read ports load from the post-write view on every edge.
    always_comb begin
        read_one_d = masked(bus.RS_ADDR, regs_d[bus.RS_ADDR]);
        read_two_d = masked(bus.RT_ADDR, regs_d[bus.RT_ADDR]);
    end

    // Dump sequencer: start at index 0, advance on each accepted beat, stop after the last.
    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        case (state_q)
            IDLE: begin
                if (bus.DUMP_START) begin
                    state_d     = SEND;
                    dump_addr_d = '0;
                    dump_data_d = masked('0, regs_d[0]);
                end
            end
            SEND: begin
                if (bus.DUMP_READY) begin
                    if (dump_addr_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                        dump_data_d = masked(dump_addr_d, regs_d[dump_addr_d]);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        dump_valid_d = (state_d == SEND);
    end

    // All state, including the dump FSM and its registered outputs, with async clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            read_one_q   <= '0;
            read_two_q   <= '0;
            state_q      <= IDLE;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            read_one_q   <= read_one_d;
            read_two_q   <= read_two_d;
            state_q      <= state_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
        end
    end

    assign bus.READ_DATA_ONE = read_one_q;
    assign bus.READ_DATA_TWO = read_two_q;
    assign bus.DUMP_VALID    = dump_valid_q;
    assign bus.DUMP_BUSY     = dump_valid_q;
    assign bus.DUMP_ADDR     = dump_addr_q;
    assign bus.DUMP_DATA     = dump_data_q;
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001: Parameter DATA_W, default 8, SHALL set the register and data-port width in bits (legal range 1..32).
REQ-002: Parameter ADDR_W, default 2, SHALL set the address width; register count NREGS = 2**ADDR_W.
REQ-003: Parameter ZERO_REG, default 0, SHALL, when 1, make register 0 read as zero and ignore writes to it.
REQ-004: CLK  in  1  clock; all state SHALL update on the rising edge.
REQ-005: RST  in  1  reset, asynchronous, active-high.
REQ-006: REGWRITE  in  1  write enable.
REQ-007: REGDST  in  1  write-target select: 1 = RD_ADDR, 0 = RT_ADDR.
REQ-008: RS_ADDR, RT_ADDR, RD_ADDR  in  ADDR_W each  read port 1 address, read port 2 address, and alternate write address.
REQ-009: WR_DATA  in  DATA_W  write data.
REQ-010: READ_DATA_ONE, READ_DATA_TWO  out  DATA_W each  registered read data for RS_ADDR and RT_ADDR respectively.
REQ-011: DUMP_START  in  1  single-cycle request to stream out all registers.
REQ-012: DUMP_READY  in  1  sink ready for the dump stream.
REQ-013: DUMP_VALID  out  1  dump beat valid.
REQ-014: DUMP_BUSY  out  1  dump in progress.
REQ-015: DUMP_ADDR  out  ADDR_W  index of the current dump beat.
REQ-016: DUMP_DATA  out  DATA_W  contents of register DUMP_ADDR.

Function
REQ-017: A write SHALL be synchronous: at a rising edge with REGWRITE=1, the register at the write target (REQ-007) SHALL take WR_DATA.
REQ-018: Read ports SHALL have 1-cycle latency: each rising edge SHALL load READ_DATA_ONE/TWO from RS_ADDR/RT_ADDR.
REQ-019: Write-through bypass: if the same edge writes the address being read, the read output SHALL take WR_DATA, not the old value.
REQ-020: If ZERO_REG=1, any read or dump of address 0 SHALL return 0, and writes to address 0 SHALL have no effect, including no bypass.
REQ-021: The dump FSM SHALL have states IDLE and SEND.
REQ-022: IDLE->SEND SHALL occur on DUMP_START=1, with index 0; DUMP_START SHALL be ignored in SEND.
REQ-023: DUMP_BUSY and DUMP_VALID SHALL be 1 exactly while in SEND.
REQ-024: A dump beat SHALL transfer when DUMP_VALID=1 and DUMP_READY=1 on a rising edge.
REQ-025: DUMP_DATA SHALL be registered when the index is set, with write bypass per REQ-019. It SHALL be held stable, together with DUMP_ADDR, until the beat transfers, even if the register is rewritten meanwhile.
REQ-026: On transfer of index k < NREGS-1, the index SHALL advance to k+1. On transfer of index NREGS-1, the FSM SHALL return to IDLE with no wrap.
REQ-027: DUMP_READY=0 SHALL stall the dump indefinitely with no beat lost or duplicated.
REQ-028: Register writes and port reads SHALL continue unaffected during a dump.
REQ-029: In IDLE, DUMP_ADDR and DUMP_DATA SHALL hold their last values.

Reset
REQ-030: RST=1 SHALL immediately clear all registers, READ_DATA_ONE/TWO, DUMP_ADDR and DUMP_DATA to 0, and force the FSM to IDLE; DUMP_VALID and DUMP_BUSY SHALL be 0.
REQ-031: RST asserted mid-dump SHALL abort the dump; no further beats SHALL appear until a new DUMP_START after reset release.
REQ-032: While RST=1, writes and DUMP_START SHALL be ignored.

Verification
REQ-033: Write then read (defaults): write 0xA5 to reg 2 via REGDST=1, RD_ADDR=2; next cycle RS_ADDR=2 -> READ_DATA_ONE=0xA5 one edge later.
REQ-034: Bypass: RT_ADDR=1, REGDST=0, REGWRITE=1, WR_DATA=0x3C in one cycle -> READ_DATA_TWO=0x3C after that same edge.
REQ-035: ZERO_REG=1: write 0xFF to reg 0 -> reads and dump beat 0 return 0x00.
REQ-036: Dump with regs {0x11,0x22,0x33,0x44} and DUMP_READY toggling 1,0,1,0... -> beats (0,0x11),(1,0x22),(2,0x33),(3,0x44) each held through stalls, then DUMP_BUSY=0.
REQ-037: Stable dump data: while beat 1 (0x22) stalls, write 0x99 to reg 1 -> DUMP_DATA stays 0x22 until transfer.
REQ-038: Async reset at beat 2 of a dump, between clock edges -> all outputs 0 and DUMP_VALID=0 immediately, all registers read 0 afterwards.
